// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data ports.
// One request/ready transaction at a time; results return with a one-cycle ack pulse.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  arb_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_ACK_I  = 3'd3,
    S_ACK_D  = 3'd4
  } state_t;

  localparam logic [3:0] MAX_DS = 4'(MAX_DSTREAK);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_DS) ? MAX_DS : v + 4'd1;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_dstreak;
  logic [3:0]              w_dstreak_nxt;
  logic                    r_mem_valid;
  logic                    w_mem_valid_nxt;
  logic                    r_mem_we;
  logic                    w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [ADDR_WIDTH-1:0]   w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [DATA_WIDTH-1:0]   w_mem_wdata_nxt;
  logic [DATA_WIDTH-1:0]   r_if_rdata;
  logic [DATA_WIDTH-1:0]   w_if_rdata_nxt;
  logic [DATA_WIDTH-1:0]   r_d_rdata;
  logic [DATA_WIDTH-1:0]   w_d_rdata_nxt;
  logic                    r_if_ack;
  logic                    r_d_ack;
  logic                    r_busy;
  logic                    w_grant_d;
  logic                    w_grant_i;

  // Data wins ties unless it has already starved a waiting fetch MAX_DSTREAK times.
  always_comb begin
    w_grant_d = (r_state == S_IDLE) && d_req && (!if_req || (r_dstreak != MAX_DS));
    w_grant_i = (r_state == S_IDLE) && if_req && !w_grant_d;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = S_BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = S_BUSY_I;
        end
      end
      S_BUSY_I: if (mem_ready) w_state_nxt = S_ACK_I;
      S_BUSY_D: if (mem_ready) w_state_nxt = S_ACK_D;
      S_ACK_I:  w_state_nxt = S_IDLE;
      S_ACK_D:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_dstreak_nxt   = r_dstreak;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    if (w_grant_d) begin
      w_mem_valid_nxt = 1'b1;
      w_mem_we_nxt    = d_we;
      w_mem_addr_nxt  = d_addr;
      w_mem_wdata_nxt = d_wdata;
      w_dstreak_nxt   = if_req ? sat_inc(r_dstreak) : 4'd0;
    end else if (w_grant_i) begin
      w_mem_valid_nxt = 1'b1;
      w_mem_we_nxt    = 1'b0;
      w_mem_addr_nxt  = if_addr;
      w_mem_wdata_nxt = '0;
      w_dstreak_nxt   = 4'd0;
    end
    if ((r_state == S_BUSY_I) && mem_ready) begin
      w_mem_valid_nxt = 1'b0;
      w_if_rdata_nxt  = mem_rdata;
    end
    // Stores complete silently; only loads overwrite the held load data.
    if ((r_state == S_BUSY_D) && mem_ready) begin
      w_mem_valid_nxt = 1'b0;
      if (!r_mem_we) w_d_rdata_nxt = mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dstreak   <= 4'd0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dstreak   <= w_dstreak_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_if_ack    <= (w_state_nxt == S_ACK_I);
      r_d_ack     <= (w_state_nxt == S_ACK_D);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_ack    = r_if_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign mem_valid = r_mem_valid;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign arb_busy  = r_busy;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table, directed corner sequences and a
// randomized run scored against a transaction-level model of the arbiter.
module tb_unified_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          arb_busy;

  always #5 clock = ~clock;

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DSTREAK(MAXD)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          waits;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vt[6];

  // Starts in an IDLE cycle with no requests, ends in the IDLE cycle after the ack.
  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    tick;
    check1($sformatf("v%0d_valid", idx), mem_valid, 1'b1);
    check1($sformatf("v%0d_we", idx), mem_we, v.is_d & v.we);
    check32($sformatf("v%0d_addr", idx), mem_addr, v.addr);
    check1($sformatf("v%0d_busy", idx), arb_busy, 1'b1);
    if (v.is_d && v.we) check32($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
    for (int w = 0; w < v.waits; w++) begin
      mem_ready = 1'b0; mem_rdata = ~v.mrdata;
      tick;
      check1($sformatf("v%0d_w%0d_valid", idx, w), mem_valid, 1'b1);
      check1($sformatf("v%0d_w%0d_we", idx, w), mem_we, v.is_d & v.we);
      check32($sformatf("v%0d_w%0d_addr", idx, w), mem_addr, v.addr);
      if (v.is_d && v.we) check32($sformatf("v%0d_w%0d_wdata", idx, w), mem_wdata, v.wdata);
      check1($sformatf("v%0d_w%0d_noack", idx, w), if_ack | d_ack, 1'b0);
    end
    mem_ready = 1'b1; mem_rdata = v.mrdata;
    tick;
    check1($sformatf("v%0d_if_ack", idx), if_ack, ~v.is_d);
    check1($sformatf("v%0d_d_ack", idx), d_ack, v.is_d);
    check32($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_if);
    check32($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_d);
    check1($sformatf("v%0d_valid_low", idx), mem_valid, 1'b0);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick;
    check1($sformatf("v%0d_ack_gone", idx), if_ack | d_ack, 1'b0);
    check1($sformatf("v%0d_idle", idx), arb_busy, 1'b0);
  endtask

  // Randomized-run model state
  logic [31:0] mem_m[16];
  int          cyc, free_cyc, streak;
  bit          in_txn, cur_d, cur_we, p_complete;
  logic [31:0] cur_addr, cur_wdata, p_rdata, last_if, last_d;
  logic        p_if_req, p_d_req, p_d_we;
  logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
  bit          exp_i, exp_d, win_d;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g;
    bit  prev_valid;
    bit  done;
    vt[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h2002000A, 0, 32'h2002000A, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h040, 32'hDEADBEEF, 32'h55555555, 3, 32'h2002000A, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h080, 32'h0,        32'h12345678, 0, 32'h2002000A, 32'h12345678};
    vt[3] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'hA5A5F00F, 1, 32'hA5A5F00F, 32'h12345678};
    vt[4] = '{1'b1, 1'b1, 32'h044, 32'h0BADF00D, 32'h11111111, 2, 32'hA5A5F00F, 32'h12345678};
    vt[5] = '{1'b1, 1'b0, 32'h088, 32'h0,        32'hCAFEBABE, 1, 32'hA5A5F00F, 32'hCAFEBABE};

    idle_inputs();
    reset = 1'b1;
    tick;
    tick;
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_d_rdata", d_rdata, 32'h0);
    check1("rst_if_ack", if_ack, 1'b0);
    check1("rst_d_ack", d_ack, 1'b0);
    check1("rst_mem_valid", mem_valid, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check1("rst_busy", arb_busy, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // Both ports held high: pattern must be D,D,D,D,I repeated.
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    g = 0; prev_valid = 1'b0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      tick;
      if (mem_valid && !prev_valid) begin
        g++;
        check1($sformatf("streak_grant%0d_is_fetch", g), (mem_addr == 32'h200), (g % 5 == 0));
        if (g == 10) done = 1'b1;
      end
      prev_valid = mem_valid;
    end
    check32("streak_grant_count", 32'(g), 32'd10);
    if_req = 1'b0; d_req = 1'b0;
    tick;
    check1("streak_last_if_ack", if_ack, 1'b1);
    mem_ready = 1'b0;
    tick;
    check1("streak_idle", arb_busy, 1'b0);

    // Load then back-to-back fetch while fetch waits.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'h120;
    tick;
    check32("b2b_first_addr", mem_addr, 32'h80);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    tick;
    check1("b2b_d_ack", d_ack, 1'b1);
    check32("b2b_d_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    tick;
    check1("b2b_idle_busy", arb_busy, 1'b0);
    tick;
    check1("b2b_fetch_valid", mem_valid, 1'b1);
    check32("b2b_fetch_addr", mem_addr, 32'h120);
    check1("b2b_fetch_we", mem_we, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h0F0F1234;
    tick;
    check1("b2b_if_ack", if_ack, 1'b1);
    check32("b2b_if_rdata", if_rdata, 32'h0F0F1234);
    check32("b2b_d_rdata_kept", d_rdata, 32'h12345678);
    if_req = 1'b0; mem_ready = 1'b0;
    tick;

    // Reset while a store is stuck in wait states.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'h77;
    tick;
    check1("rstmid_valid", mem_valid, 1'b1);
    tick;
    reset = 1'b1; d_req = 1'b0;
    tick;
    check1("rstmid_valid_drop", mem_valid, 1'b0);
    check1("rstmid_busy", arb_busy, 1'b0);
    check1("rstmid_no_ack", d_ack, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      check1($sformatf("rstmid_quiet%0d", c), d_ack | mem_valid, 1'b0);
    end
    if_req = 1'b1; if_addr = 32'h140;
    tick;
    check1("rstmid_fetch_valid", mem_valid, 1'b1);
    check32("rstmid_fetch_addr", mem_addr, 32'h140);
    mem_ready = 1'b1; mem_rdata = 32'h600DCAFE;
    tick;
    check1("rstmid_if_ack", if_ack, 1'b1);
    check32("rstmid_if_rdata", if_rdata, 32'h600DCAFE);
    if_req = 1'b0; mem_ready = 1'b0;
    tick;
    check1("rstmid_if_ack_gone", if_ack, 1'b0);

    // Fetch req pulsed only while busy is never serviced.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    tick;
    if_req = 1'b1; if_addr = 32'h1F0;
    tick;
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h3;
    tick;
    check1("drop_d_ack", d_ack, 1'b1);
    d_req = 1'b0; mem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      check1($sformatf("drop_no_if_ack%0d", c), if_ack, 1'b0);
      check1($sformatf("drop_no_valid%0d", c), mem_valid, 1'b0);
    end

    // Randomized run against the transaction-level model.
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    idle_inputs();
    reset = 1'b1;
    cyc = 0; free_cyc = 1; streak = 0;
    in_txn = 1'b0; cur_d = 1'b0; cur_we = 1'b0; p_complete = 1'b0;
    cur_addr = '0; cur_wdata = '0; p_rdata = '0; last_if = '0; last_d = '0;
    p_if_req = 1'b0; p_d_req = 1'b0; p_d_we = 1'b0;
    p_if_addr = '0; p_d_addr = '0; p_d_wdata = '0;
    for (int it = 0; it < 3000; it++) begin
      tick;
      cyc++;
      exp_i = 1'b0; exp_d = 1'b0;
      if (cyc - 1 == free_cyc) begin
        if (p_if_req || p_d_req) begin
          win_d = p_d_req && !(p_if_req && streak == MAXD);
          if (win_d) streak = p_if_req ? ((streak + 1 > MAXD) ? MAXD : streak + 1) : 0;
          else streak = 0;
          check1("rnd_grant_valid", mem_valid, 1'b1);
          if (win_d) begin
            check1("rnd_grant_d_we", mem_we, p_d_we);
            check32("rnd_grant_d_addr", mem_addr, p_d_addr);
            if (p_d_we) check32("rnd_grant_d_wdata", mem_wdata, p_d_wdata);
            cur_addr = p_d_addr; cur_wdata = p_d_wdata; cur_we = p_d_we;
          end else begin
            check1("rnd_grant_i_we", mem_we, 1'b0);
            check32("rnd_grant_i_addr", mem_addr, p_if_addr);
            cur_addr = p_if_addr; cur_wdata = '0; cur_we = 1'b0;
          end
          in_txn = 1'b1; cur_d = win_d; free_cyc = -10;
        end else begin
          free_cyc = cyc;
        end
      end
      if (in_txn && p_complete) begin
        in_txn = 1'b0; free_cyc = cyc + 1;
        if (cur_d) begin
          exp_d = 1'b1;
          if (!cur_we) last_d = p_rdata;
        end else begin
          exp_i = 1'b1;
          last_if = p_rdata;
        end
      end
      check1("rnd_if_ack", if_ack, exp_i);
      check1("rnd_d_ack", d_ack, exp_d);
      check32("rnd_if_rdata", if_rdata, last_if);
      check32("rnd_d_rdata", d_rdata, last_d);
      check1("rnd_mem_valid", mem_valid, in_txn);
      check1("rnd_busy", arb_busy, in_txn | exp_i | exp_d);

      reset = 1'b0;
      mem_ready = ($urandom_range(0, 2) != 0);
      p_complete = in_txn && mem_ready;
      if (p_complete && cur_we) begin
        mem_m[cur_addr[5:2]] = cur_wdata;
        mem_rdata = $urandom;
      end else if (p_complete) begin
        p_rdata = mem_m[cur_addr[5:2]];
        mem_rdata = p_rdata;
      end else begin
        mem_rdata = $urandom;
      end
      if (exp_i || !if_req) begin
        if_req = ($urandom_range(0, 2) == 0);
        if (if_req) if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (exp_d || !d_req) begin
        d_req = ($urandom_range(0, 1) == 0);
        if (d_req) begin
          d_we = ($urandom_range(0, 1) == 0);
          d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          d_wdata = $urandom;
        end
      end
      p_if_req = if_req; p_if_addr = if_addr;
      p_d_req = d_req; p_d_we = d_we; p_d_addr = d_addr; p_d_wdata = d_wdata;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

- Shares one single-ported unified memory between the processor's instruction-fetch port and data port.
- Arbitrates between the two ports, drives one request/ready memory transaction at a time, and returns read data with a one-cycle acknowledge pulse.
- Sits between the pipelined core's fetch/data interfaces and the memory model. The core stalls on each port until that port's ack arrives.

## Interface

Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch waits (1..15)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with stable if_addr until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word; valid in the if_ack cycle, held until the next if_ack
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request (load or store); held with stable d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data; valid in the d_ack cycle, held until the next load ack (stores leave it unchanged)
- d_ack  out  1  one-cycle completion pulse for data
- mem_valid  out  1  memory request valid; held until accepted
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory completes the transaction in any cycle where mem_valid=1 and mem_ready=1
- mem_rdata  in  DATA_WIDTH  read data; valid when mem_ready=1
- arb_busy  out  1  1 whenever state is not IDLE

## Operation

- State machine: IDLE, BUSY_I, BUSY_D, ACK_I, ACK_D. All outputs are registered.
- IDLE, arbitration on the current cycle's requests:
  - Only d_req=1 → grant data.
  - Only if_req=1 → grant fetch.
  - Both requests high → grant data, unless dstreak == MAX_DSTREAK, in which case grant fetch.
  - Neither request → stay in IDLE.
- Grant action: latch the winner's addr, wdata and we into mem_* (fetch sets mem_we=0), set mem_valid=1, then go to BUSY_I or BUSY_D.
- BUSY_x:
  - mem_* outputs stay stable.
  - On mem_ready=1: capture mem_rdata into if_rdata (fetch) or d_rdata (load only), clear mem_valid, go to ACK_x.
  - On mem_ready=0: stay; there is no timeout.
- ACK_x: pulse the matching ack for exactly one cycle, then return to IDLE. No arbitration happens in ACK; the requester's req line is ignored there.
- dstreak counter, width 4:
  - Data grant with if_req=1 → dstreak increments, saturating at MAX_DSTREAK.
  - Data grant with if_req=0 → dstreak clears to 0.
  - Any fetch grant → dstreak clears to 0.
- Port inputs are sampled only at grant, so changes in BUSY or ACK have no effect.
- A req dropped before grant is simply not serviced. A req dropped after grant does not cancel the transaction; the ack is still produced.

## Timing

- Reset values: every output is 0 (if_rdata, d_rdata, mem_* = 0; both acks = 0; arb_busy = 0); state = IDLE; dstreak = 0.
- Reset mid-transaction: at the next edge mem_valid drops to 0, no ack is issued and the transaction is abandoned.
- Latency, with req first seen in IDLE at cycle 0:
  - mem_valid=1 from cycle 1.
  - If mem_ready=1 in cycle 1+W (W wait states), ack=1 and rdata valid in cycle 2+W.
  - IDLE again in cycle 3+W.
- Minimum latency is 2 cycles. Peak throughput is one transaction per 3 cycles.
- Back-to-back: a requester may raise a new request in the cycle after its ack. It is arbitrated in that IDLE cycle.
- The pending port's req stays visible throughout, so in the IDLE cycle after an ACK both ports compete under normal arbitration.

## Test plan

- **Single fetch:** if_req=1, if_addr=0x100, mem_ready=1 the cycle after mem_valid, mem_rdata=0x2002000A → mem_addr=0x100 and mem_we=0 in cycle 1; if_ack=1 with if_rdata=0x2002000A in cycle 2; if_ack=0 in cycle 3; arb_busy high in cycles 1-2.
- **Store with wait states:** d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready held low 3 cycles → mem_valid, mem_we=1 and mem_addr/mem_wdata stable for 4 cycles; d_ack in cycle 5; d_rdata unchanged.
- **Simultaneous requests, MAX_DSTREAK=4, both reqs held continuously:** first 4 grants go to data, 5th grant to fetch; dstreak back to 0 after the fetch grant.
- **Load then fetch back-to-back:** load at 0x80 returns 0x12345678 on d_rdata. if_req stays high while the data req drops after d_ack → fetch granted in the IDLE cycle after ACK_D; d_rdata still 0x12345678 after the fetch completes.
- **Reset mid-BUSY_D:** reset asserted for 1 cycle while mem_ready=0 → mem_valid=0 and state IDLE after the edge; no d_ack ever pulses; a fresh fetch afterwards completes normally with 2-cycle latency.
- **Req drop before grant:** if_req pulsed for one cycle while arb_busy=1 → no fetch transaction and no if_ack.
